// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: datapath-to-controller status and control-strobe bundle
interface multicycle_controller_if;
    logic [6:0]  opcode;
    logic        zero;
    logic        memready;
    logic        pcwrite;
    logic        adrsrc;
    logic        irwrite;
    logic        memwrite;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic [1:0]  alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  aluop;
    logic [1:0]  immsrc;
    logic [3:0]  state;
    logic        retire;
    logic        illegal;
    logic [31:0] instret;
    modport master (
        input  opcode, zero, memready,
        output pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc, alusrca,
               alusrcb, aluop, immsrc, state, retire, illegal, instret
    );
    modport slave (
        output opcode, zero, memready,
        input  pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc, alusrca,
               alusrcb, aluop, immsrc, state, retire, illegal, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RISC-V multicycle control FSM with retire counter and trap state
module multicycle_controller (
    input logic clk,
    input logic reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
        MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9,
        BEQ = 4'd10, TRAP = 4'd11
    } state_t;
    state_t st, nxt;
    logic [31:0] count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= FETCH;
            count <= '0;
        end else begin
            st <= nxt;
            if (bus.retire) count <= count + 32'd1;
        end
    end
    always_comb begin
        nxt = FETCH;
        bus.pcwrite = 1'b0;
        bus.adrsrc = 1'b0;
        bus.irwrite = 1'b0;
        bus.memwrite = 1'b0;
        bus.regwrite = 1'b0;
        bus.resultsrc = 2'b00;
        bus.alusrca = 2'b00;
        bus.alusrcb = 2'b00;
        bus.aluop = 2'b00;
        bus.retire = 1'b0;
        case (st)
            FETCH: begin
                nxt = bus.memready ? DECODE : FETCH;
                bus.alusrcb = 2'b10;
                bus.resultsrc = 2'b10;
                bus.irwrite = bus.memready;
                bus.pcwrite = bus.memready;
            end
            DECODE: begin
                case (bus.opcode)
                    7'b0000011, 7'b0100011: nxt = MEMADR;
                    7'b0110011: nxt = EXECR;
                    7'b0010011: nxt = EXECI;
                    7'b1101111: nxt = JAL;
                    7'b1100011: nxt = BEQ;
                    default: nxt = TRAP;
                endcase
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b01;
            end
            MEMADR: begin
                nxt = (bus.opcode == 7'b0000011) ? MEMREAD : MEMWRITE;
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
            end
            MEMREAD: begin
                nxt = bus.memready ? MEMWB : MEMREAD;
                bus.adrsrc = 1'b1;
            end
            MEMWB: begin
                bus.resultsrc = 2'b01;
                bus.regwrite = 1'b1;
                bus.retire = 1'b1;
            end
            MEMWRITE: begin
                nxt = bus.memready ? FETCH : MEMWRITE;
                bus.adrsrc = 1'b1;
                bus.memwrite = 1'b1;
                bus.retire = bus.memready;
            end
            EXECR: begin
                nxt = ALUWB;
                bus.alusrca = 2'b10;
                bus.aluop = 2'b10;
            end
            EXECI: begin
                nxt = ALUWB;
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                bus.aluop = 2'b10;
            end
            ALUWB: begin
                bus.regwrite = 1'b1;
                bus.retire = 1'b1;
            end
            JAL: begin
                nxt = ALUWB;
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b10;
                bus.pcwrite = 1'b1;
            end
            BEQ: begin
                bus.alusrca = 2'b10;
                bus.aluop = 2'b01;
                bus.pcwrite = bus.zero;
                bus.retire = 1'b1;
            end
            TRAP: nxt = TRAP;
            default: nxt = FETCH;
        endcase
    end
    assign bus.immsrc = (bus.opcode == 7'b0100011) ? 2'b01 :
                        (bus.opcode == 7'b1100011) ? 2'b10 :
                        (bus.opcode == 7'b1101111) ? 2'b11 : 2'b00;
    assign bus.state = st;
    assign bus.illegal = (st == TRAP);
    assign bus.instret = count;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for the multicycle controller
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    int errors = 0;
    int checks = 0;
    multicycle_controller_if bus ();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus.master));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic adv;
        @(negedge clk);
        #1;
    endtask
    initial begin
        int lw_s[6];
        lw_s = '{0, 1, 2, 3, 4, 0};
        bus.opcode = 7'b0000011;
        bus.zero = 1'b0;
        bus.memready = 1'b1;
        reset = 1'b1;
        #12;
        check("rst_state", {28'd0, bus.state}, 32'd0);
        check("rst_instret", bus.instret, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check("rst_irwrite", {31'd0, bus.irwrite}, 32'd1);
        check("rst_pcwrite", {31'd0, bus.pcwrite}, 32'd1);
        check("rst_alusrcb", {30'd0, bus.alusrcb}, 32'd2);
        check("rst_resultsrc", {30'd0, bus.resultsrc}, 32'd2);
        check("rst_strobes", {28'd0, bus.memwrite, bus.regwrite, bus.retire, bus.adrsrc}, 32'd0);
        bus.memready = 1'b0;
        #1;
        check("rst_irwrite_mr0", {31'd0, bus.irwrite}, 32'd0);
        check("rst_pcwrite_mr0", {31'd0, bus.pcwrite}, 32'd0);
        bus.memready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        // lw with memready tied high: 5 cycles
        for (int i = 0; i < 6; i++) begin
            check("lw_state", {28'd0, bus.state}, lw_s[i]);
            check("lw_regwrite", {31'd0, bus.regwrite}, (lw_s[i] == 4) ? 32'd1 : 32'd0);
            check("lw_retire", {31'd0, bus.retire}, (lw_s[i] == 4) ? 32'd1 : 32'd0);
            if (i < 5) adv();
        end
        check("lw_instret", bus.instret, 32'd1);
        bus.opcode = 7'b0100011;
        #1;
        check("sw_immsrc", {30'd0, bus.immsrc}, 32'd1);
        adv(); adv(); adv();
        check("sw_state_memwrite", {28'd0, bus.state}, 32'd5);
        bus.memready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", {28'd0, bus.state}, 32'd5);
            check("sw_wait_memwrite", {31'd0, bus.memwrite}, 32'd1);
            check("sw_wait_retire", {31'd0, bus.retire}, 32'd0);
            adv();
        end
        bus.memready = 1'b1;
        #1;
        check("sw_last_memwrite", {31'd0, bus.memwrite}, 32'd1);
        check("sw_last_retire", {31'd0, bus.retire}, 32'd1);
        adv();
        check("sw_exit_state", {28'd0, bus.state}, 32'd0);
        check("sw_instret", bus.instret, 32'd2);
        bus.opcode = 7'b1100011;
        bus.zero = 1'b1;
        adv(); adv();
        check("beq1_state", {28'd0, bus.state}, 32'd10);
        check("beq1_pcwrite", {31'd0, bus.pcwrite}, 32'd1);
        check("beq1_retire", {31'd0, bus.retire}, 32'd1);
        check("beq1_aluop", {30'd0, bus.aluop}, 32'd1);
        check("beq1_immsrc", {30'd0, bus.immsrc}, 32'd2);
        adv();
        check("beq1_exit", {28'd0, bus.state}, 32'd0);
        check("beq1_instret", bus.instret, 32'd3);
        bus.zero = 1'b0;
        adv(); adv();
        check("beq0_state", {28'd0, bus.state}, 32'd10);
        check("beq0_pcwrite", {31'd0, bus.pcwrite}, 32'd0);
        check("beq0_retire", {31'd0, bus.retire}, 32'd1);
        adv();
        check("beq0_exit", {28'd0, bus.state}, 32'd0);
        check("beq0_instret", bus.instret, 32'd4);
        bus.opcode = 7'b1101111;
        adv(); adv();
        check("jal_state", {28'd0, bus.state}, 32'd9);
        check("jal_pcwrite", {31'd0, bus.pcwrite}, 32'd1);
        check("jal_immsrc", {30'd0, bus.immsrc}, 32'd3);
        adv();
        check("jal_aluwb", {28'd0, bus.state}, 32'd7);
        check("jal_regwrite", {31'd0, bus.regwrite}, 32'd1);
        adv();
        check("jal_instret", bus.instret, 32'd5);
        // async reset while stalled in MEMREAD
        bus.opcode = 7'b0000011;
        adv(); adv(); adv();
        check("ar_memread", {28'd0, bus.state}, 32'd3);
        bus.memready = 1'b0;
        adv();
        check("ar_memread_hold", {28'd0, bus.state}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", {28'd0, bus.state}, 32'd0);
        check("ar_instret", bus.instret, 32'd0);
        check("ar_regwrite", {31'd0, bus.regwrite}, 32'd0);
        adv();
        check("ar_hold_state", {28'd0, bus.state}, 32'd0);
        check("ar_hold_regwrite", {31'd0, bus.regwrite}, 32'd0);
        bus.memready = 1'b1;
        reset = 1'b0;
        bus.opcode = 7'b0010011;
        #1;
        adv(); adv();
        check("itype_state", {28'd0, bus.state}, 32'd8);
        check("itype_aluop", {30'd0, bus.aluop}, 32'd2);
        adv(); adv();
        check("itype_exit", {28'd0, bus.state}, 32'd0);
        check("itype_instret", bus.instret, 32'd1);
        bus.opcode = 7'b0000000;
        adv(); adv();
        check("trap_state", {28'd0, bus.state}, 32'd11);
        check("trap_illegal", {31'd0, bus.illegal}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            adv();
            check("trap_strobes", {28'd0, bus.pcwrite, bus.irwrite, bus.memwrite, bus.regwrite}, 32'd0);
            check("trap_instret", bus.instret, 32'd1);
        end
        check("trap_still", {28'd0, bus.state}, 32'd11);
        #2;
        reset = 1'b1;
        #1;
        check("trap_rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check("trap_rst_state", {28'd0, bus.state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.opcode = 7'b0110011;
        #1;
        force dut.count = 32'hFFFF_FFFF;
        #1;
        release dut.count;
        #1;
        check("wrap_preload", bus.instret, 32'hFFFF_FFFF);
        adv();
        check("rtype_decode", {28'd0, bus.state}, 32'd1);
        adv();
        check("rtype_execr", {28'd0, bus.state}, 32'd6);
        check("rtype_alusrca", {30'd0, bus.alusrca}, 32'd2);
        adv();
        check("rtype_aluwb", {28'd0, bus.state}, 32'd7);
        check("rtype_retire", {31'd0, bus.retire}, 32'd1);
        adv();
        check("wrap_instret", bus.instret, 32'd0);
        check("wrap_state", {28'd0, bus.state}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: `clk` input 1 is the clock; all state updates on the rising edge. `reset` input 1 forces the reset state immediately, independent of `clk`.
REQ-002 The ports SHALL be:
- `opcode` input 7: instruction opcode from the instruction register.
- `zero` input 1: ALU zero flag.
- `memready` input 1: memory has completed the current access this cycle.
- `pcwrite` output 1: PC register enable.
- `adrsrc` output 1: memory address select (0 = PC, 1 = ALU result register).
- `irwrite` output 1: instruction register enable.
- `memwrite` output 1: data memory write strobe.
- `regwrite` output 1: register file write enable.
- `resultsrc` output 2: result mux select (00 ALUOut, 01 Data, 10 ALUResult).
- `alusrca` output 2: ALU A select (00 PC, 01 OldPC, 10 rs1).
- `alusrcb` output 2: ALU B select (00 rs2, 01 ImmExt, 10 constant 4).
- `aluop` output 2: ALU decoder class (00 add, 01 subtract/compare, 10 funct-decoded).
- `immsrc` output 2: immediate format (00 I, 01 S, 10 B, 11 J).
- `state` output 4: current FSM state encoding.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `illegal` output 1: sticky unsupported-opcode flag.
- `instret` output 32: retired-instruction count.

Function
REQ-003 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=11. Codes 12-15 SHALL go to FETCH on the next edge.
REQ-004 Transitions:
- FETCH goes to DECODE only when memready=1, otherwise it stays in FETCH.
- DECODE goes by opcode: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1101111 to JAL; 1100011 to BEQ; any other opcode to TRAP.
- MEMADR goes to MEMREAD if opcode=0000011, otherwise to MEMWRITE.
- MEMREAD goes to MEMWB when memready=1, otherwise it stays.
- MEMWRITE goes to FETCH when memready=1, otherwise it stays.
- MEMWB goes to FETCH.
- EXECR, EXECI and JAL go to ALUWB.
- ALUWB and BEQ go to FETCH.
- TRAP stays in TRAP until reset.
REQ-005 Outputs SHALL be a combinational function of state, plus memready and zero where noted (Moore, except where noted). Any signal not listed for a state is 0.
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. irwrite=memready and pcwrite=memready.
- DECODE: alusrca=01, alusrcb=01, aluop=00.
- MEMADR: alusrca=10, alusrcb=01, aluop=00.
- MEMREAD: adrsrc=1, resultsrc=00.
- MEMWB: resultsrc=01, regwrite=1.
- MEMWRITE: adrsrc=1, memwrite=1, held for the whole state.
- EXECR: alusrca=10, alusrcb=00, aluop=10.
- EXECI: alusrca=10, alusrcb=01, aluop=10.
- ALUWB: resultsrc=00, regwrite=1.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcwrite=1.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, pcwrite=zero.
REQ-006 immsrc SHALL be decoded from opcode in every state: 0100011 gives 01, 1100011 gives 10, 1101111 gives 11, all others give 00.
REQ-007 retire SHALL be 1 in exactly these cycles: MEMWB; MEMWRITE with memready=1; ALUWB; BEQ. retire is 0 in all other cycles.
REQ-008 instret SHALL increment by 1 on every edge where retire=1. It wraps from 0xFFFFFFFF to 0 with no flag.
REQ-009 illegal SHALL be 1 whenever state=TRAP; it is cleared only by reset. While in TRAP: pcwrite, irwrite, memwrite and regwrite are 0, and instret holds.
REQ-010 Instruction latencies with memready tied to 1 SHALL be: lw 5 cycles; sw 4; R-type 4; I-type 4; jal 4; beq 3.
- Each cycle memready is low in a wait state adds exactly one cycle.
REQ-011 memready SHALL be ignored in every state other than FETCH, MEMREAD and MEMWRITE.

Reset
REQ-012 While reset=1, state SHALL be FETCH, instret 0, illegal 0.
- Outputs SHALL then equal the FETCH decode: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, irwrite=memready, pcwrite=memready. All other strobes are 0.
REQ-013 Asserting reset in any state, including a wait state or TRAP, SHALL abort the instruction with no further strobes. Operation resumes from FETCH on the first edge after reset deasserts.

Verification
REQ-014 The bench SHALL cover these directed scenarios:
- lw (0000011), memready=1 -> states 0,1,2,3,4,0; regwrite=1 only in state 4; retire once; instret 0 to 1.
- sw (0100011), memready low 3 cycles in MEMWRITE -> memwrite high 4 consecutive cycles; immsrc=01; exit to FETCH on the memready=1 cycle; instret +1.
- beq with zero=1, then beq with zero=0 -> pcwrite=1 in BEQ for the first only; both retire; 3 cycles each.
- opcode 0000000 -> TRAP, illegal=1; 20 further cycles keep all write strobes 0 and instret unchanged; reset clears illegal and returns state to 0.
- Asynchronous reset mid-MEMREAD, asserted between clock edges -> state=0 immediately; instret=0; no regwrite pulse.
- instret forced near wrap via 2^32 retires (or a bench force to 0xFFFFFFFF) plus one R-type -> instret=0x00000000.
